// File: rtl/icache_addr_pkg.sv
// -----------------------------------------------------------------------------
// icache_addr_pkg
// Shared definitions for the instruction/data cache address decomposers.
//   - Default cache geometry and helper functions that derive the line-offset
//     width (L) and the tag width from it.
//   - addr_mode_e: byte-address vs block-address request format.
//   - addr_fields_t: decoded request fields for the default geometry.
// -----------------------------------------------------------------------------
package icache_addr_pkg;

  localparam int XLEN_DEF             = 32;
  localparam int SETIDXBITS_DEF       = 5;
  localparam int BLOCK_OFFSETBITS_DEF = 1;
  localparam int WORD_OFFSETBITS_DEF  = 1;
  localparam int BA_BITS_DEF          = 6;

  // Bits below the set index: byte-within-word plus word-within-block.
  function automatic int calc_line_off_bits(input int block_off_bits,
                                            input int word_off_bits);
    return block_off_bits + word_off_bits;
  endfunction

  // Everything above set index and line offset is tag.
  function automatic int calc_tag_bits(input int xlen,
                                       input int setidx_bits,
                                       input int block_off_bits,
                                       input int word_off_bits);
    return xlen - setidx_bits - calc_line_off_bits(block_off_bits, word_off_bits);
  endfunction

  localparam int TAGBITS_DEF = calc_tag_bits(XLEN_DEF, SETIDXBITS_DEF,
                                             BLOCK_OFFSETBITS_DEF,
                                             WORD_OFFSETBITS_DEF);

  typedef enum logic {
    ADDR_BYTE = 1'b0,
    ADDR_BLK  = 1'b1
  } addr_mode_e;

  typedef struct packed {
    logic [TAGBITS_DEF-1:0]          tag;
    logic [SETIDXBITS_DEF-1:0]       setid;
    logic [WORD_OFFSETBITS_DEF-1:0]  word_off;
    logic [BLOCK_OFFSETBITS_DEF-1:0] byte_off;
    logic                            same_set;
  } addr_fields_t;

endpackage

// File: rtl/icache_addr_fields.sv
// -----------------------------------------------------------------------------
// icache_addr_fields
// Purely combinational split of a request address into tag / set index /
// word offset / byte offset. Shared between instruction and data caches.
//   addr      in   XLEN        request address
//   mode      in   addr_mode_e ADDR_BYTE: full byte address
//                              ADDR_BLK : block address in addr[BA_BITS-1:0]
//   tag       out  TAGBITS     tag (block mode: zero-extended upper block bits)
//   setid     out  SETIDXBITS  set index
//   word_off  out  WORD_OFFSETBITS   word within block (0 in block mode)
//   byte_off  out  BLOCK_OFFSETBITS  byte within word  (0 in block mode)
// -----------------------------------------------------------------------------
module icache_addr_fields
  import icache_addr_pkg::*;
#(
  parameter int  XLEN             = XLEN_DEF,
  parameter int  SETIDXBITS       = SETIDXBITS_DEF,
  parameter int  BLOCK_OFFSETBITS = BLOCK_OFFSETBITS_DEF,
  parameter int  WORD_OFFSETBITS  = WORD_OFFSETBITS_DEF,
  parameter int  BA_BITS          = BA_BITS_DEF,
  localparam int L                = calc_line_off_bits(BLOCK_OFFSETBITS, WORD_OFFSETBITS),
  localparam int TAGBITS          = calc_tag_bits(XLEN, SETIDXBITS,
                                                  BLOCK_OFFSETBITS, WORD_OFFSETBITS)
) (
  input  logic [XLEN-1:0]             addr,
  input  addr_mode_e                  mode,
  output logic [TAGBITS-1:0]          tag,
  output logic [SETIDXBITS-1:0]       setid,
  output logic [WORD_OFFSETBITS-1:0]  word_off,
  output logic [BLOCK_OFFSETBITS-1:0] byte_off
);

  // Tag bits available in block mode; none at all when the block address is
  // exactly as wide as the set index.
  logic [TAGBITS-1:0] blk_tag;

  if (BA_BITS > SETIDXBITS) begin : g_blk_tag
    assign blk_tag = TAGBITS'(addr[BA_BITS-1:SETIDXBITS]);
  end else begin : g_no_blk_tag
    assign blk_tag = '0;
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves a variable unassigned; otherwise synthesis infers a latch.
  always_comb begin
    tag      = addr[XLEN-1:SETIDXBITS+L];
    setid    = addr[SETIDXBITS+L-1:L];
    word_off = addr[L-1:BLOCK_OFFSETBITS];
    byte_off = addr[BLOCK_OFFSETBITS-1:0];
    if (mode == ADDR_BLK) begin
      tag      = blk_tag;
      setid    = addr[SETIDXBITS-1:0];
      word_off = '0;
      byte_off = '0;
    end
  end

endmodule

// File: rtl/icache_addr_split_pipe.sv
// -----------------------------------------------------------------------------
// icache_addr_split_pipe
// Front end of the instruction-cache lookup: decodes each accepted request
// address, tags it with a same-set hazard flag against the previously
// accepted request, and buffers the result in a 2-entry FIFO.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  request handshake; in_ready depends only on FIFO fill
//                   and flush, never on out_ready
//   in_addr         request address (block mode uses in_addr[BA_BITS-1:0])
//   in_blk_mode     0 = byte address, 1 = block address
//   flush           synchronous clear of FIFO, hazard history and counter
//   out_valid/ready result handshake at the FIFO head
//   out_tag, out_setid, out_word_off, out_byte_off, out_same_set
//                   head entry; hold their last values while empty
//   req_cnt         saturating count of accepted requests
// -----------------------------------------------------------------------------
module icache_addr_split_pipe
  import icache_addr_pkg::*;
#(
  parameter int  XLEN             = XLEN_DEF,
  parameter int  SETIDXBITS       = SETIDXBITS_DEF,
  parameter int  BLOCK_OFFSETBITS = BLOCK_OFFSETBITS_DEF,
  parameter int  WORD_OFFSETBITS  = WORD_OFFSETBITS_DEF,
  parameter int  BA_BITS          = BA_BITS_DEF,
  parameter int  CNT_W            = 16,
  localparam int TAGBITS          = calc_tag_bits(XLEN, SETIDXBITS,
                                                  BLOCK_OFFSETBITS, WORD_OFFSETBITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XLEN-1:0]             in_addr,
  input  logic                        in_blk_mode,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAGBITS-1:0]          out_tag,
  output logic [SETIDXBITS-1:0]       out_setid,
  output logic [WORD_OFFSETBITS-1:0]  out_word_off,
  output logic [BLOCK_OFFSETBITS-1:0] out_byte_off,
  output logic                        out_same_set,
  output logic [CNT_W-1:0]            req_cnt
);

  // FIFO entry: decoded fields for this geometry plus the hazard flag.
  typedef struct packed {
    logic [TAGBITS-1:0]          tag;
    logic [SETIDXBITS-1:0]       setid;
    logic [WORD_OFFSETBITS-1:0]  word_off;
    logic [BLOCK_OFFSETBITS-1:0] byte_off;
    logic                        same_set;
  } entry_t;

  localparam int DEPTH = 2;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  addr_mode_e                  mode;
  logic [TAGBITS-1:0]          dec_tag;
  logic [SETIDXBITS-1:0]       dec_setid;
  logic [WORD_OFFSETBITS-1:0]  dec_word_off;
  logic [BLOCK_OFFSETBITS-1:0] dec_byte_off;

  assign mode = addr_mode_e'(in_blk_mode);

  icache_addr_fields #(
    .XLEN             (XLEN),
    .SETIDXBITS       (SETIDXBITS),
    .BLOCK_OFFSETBITS (BLOCK_OFFSETBITS),
    .WORD_OFFSETBITS  (WORD_OFFSETBITS),
    .BA_BITS          (BA_BITS)
  ) u_fields (
    .addr     (in_addr),
    .mode     (mode),
    .tag      (dec_tag),
    .setid    (dec_setid),
    .word_off (dec_word_off),
    .byte_off (dec_byte_off)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    hist_valid_q, hist_valid_d;
  logic [SETIDXBITS-1:0]   hist_setid_q, hist_setid_d;
  logic [CNT_W-1:0]        req_cnt_q, req_cnt_d;
  // Last entry shown at the head, so outputs hold once the FIFO drains.
  entry_t                  last_q, last_d;

  entry_t push_entry;
  entry_t head;
  logic   accept;
  logic   pop;

  assign in_ready  = (cnt_q < 2'(DEPTH)) && !flush;
  assign out_valid = (cnt_q != 2'd0);
  assign accept    = in_valid && in_ready;
  // A pop offered during flush is ignored: the entries are discarded anyway.
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    push_entry.tag      = dec_tag;
    push_entry.setid    = dec_setid;
    push_entry.word_off = dec_word_off;
    push_entry.byte_off = dec_byte_off;
    push_entry.same_set = hist_valid_q && (dec_setid == hist_setid_q);
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    hist_valid_d = hist_valid_q;
    hist_setid_d = hist_setid_q;
    req_cnt_d    = req_cnt_q;
    last_d       = last_q;

    if (flush) begin
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      cnt_d        = 2'd0;
      hist_valid_d = 1'b0;
      req_cnt_d    = '0;
      if (out_valid) last_d = head;
    end else begin
      if (accept) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
        hist_valid_d    = 1'b1;
        hist_setid_d    = dec_setid;
        if (req_cnt_q != '1) req_cnt_d = req_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        last_d   = head;
      end
      unique case ({accept, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;   // idle, or push+pop keeps the fill level
      endcase
    end
  end

  // NOTE: the storage array is reset along with the control state; at two
  // entries this is cheap and keeps the outputs at a defined zero after reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      hist_valid_q <= 1'b0;
      hist_setid_q <= '0;
      req_cnt_q    <= '0;
      last_q       <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_setid_q <= hist_setid_d;
      req_cnt_q    <= req_cnt_d;
      last_q       <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  entry_t shown;
  assign shown        = out_valid ? head : last_q;
  assign out_tag      = shown.tag;
  assign out_setid    = shown.setid;
  assign out_word_off = shown.word_off;
  assign out_byte_off = shown.byte_off;
  assign out_same_set = shown.same_set;
  assign req_cnt      = req_cnt_q;

endmodule
